i_decode: RTL and testbench
===========================

Name: i_decode

Overview:
- Decode stage directly downstream of the instruction fetch unit.
- Pops one instruction per cycle from the fetch queue when the queue is non-empty and the decode output register can accept.
- Splits the instruction into MIPS-style fields, generates the extended immediate and class flags, and presents them to the issue stage through a valid/ready handshake.
- Resolves unconditional jumps (J/JAL) locally and forwards execute-stage redirects, driving the fetch unit's jump/branch redirect port.

Parameters:
DATA_WIDTH, 32, instruction and immediate width
ADDRESS_WIDTH, 32, PC width (word address)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
fetch_empty  input  1  fetch queue empty
fetch_instruction  input  DATA_WIDTH  instruction presented by fetch
fetch_pc  input  ADDRESS_WIDTH  PC of the presented instruction
fetch_read_enable  output  1  pop/advance request to fetch (combinational)
jump_branch_valid  output  1  redirect pulse to fetch (registered)
jump_branch_address  output  ADDRESS_WIDTH  redirect target (registered)
ex_redirect_valid  input  1  execute-stage redirect request (mispredict/JR)
ex_redirect_address  input  ADDRESS_WIDTH  execute-stage redirect target
dec_valid  output  1  decoded instruction valid
dec_ready  input  1  issue stage accepts
dec_pc, dec_instruction  output  ADDRESS_WIDTH / DATA_WIDTH  captured PC and raw word
dec_opcode  output  6  instr[31:26]
dec_rs, dec_rt, dec_rd, dec_shamt  output  5 each  instr[25:21], [20:16], [15:11], [10:6]
dec_funct  output  6  instr[5:0]
dec_imm  output  DATA_WIDTH  extended immediate
dec_is_alu_r, dec_is_alu_i, dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_is_link, dec_illegal  output  1 each  class flags
instr_count  output  CNT_WIDTH  instructions handed to issue
redirect_count  output  CNT_WIDTH  redirect pulses issued

Behaviour:
- Reset:
  - state = RUN.
  - dec_valid = 0; all dec_* fields = 0.
  - jump_branch_valid = 0, jump_branch_address = 0.
  - Both counters = 0.
  - A reset asserted mid-operation discards the held instruction and any pending redirect.
- Accept (combinational): fetch_read_enable = (state==RUN) && !ex_redirect_valid && !fetch_empty && (!dec_valid || dec_ready). When it is 1, the output registers load from fetch_* at the edge (1-cycle latency).
- Output register:
  - dec_valid is set on accept.
  - It is cleared on dec_valid && dec_ready with no new accept in the same cycle.
  - Fields stay stable while dec_valid && !dec_ready.
- Decode, by opcode:
  - 0x00 → alu_r.
  - 0x02 → jump.
  - 0x03 → jump + link.
  - 0x04–0x07 → branch.
  - 0x08–0x0F → alu_i.
  - 0x20, 0x21, 0x23, 0x24, 0x25 → load.
  - 0x28, 0x29, 0x2B → store.
  - All other opcodes → illegal, with all other flags 0.
  - Exactly one class flag (or illegal) is set; dec_is_link is set only for JAL.
- Immediate:
  - 0x0C/0x0D/0x0E: zero-extend instr[15:0].
  - 0x0F: {instr[15:0], 16'b0}.
  - All other opcodes: sign-extend instr[15:0].
- Jump resolution:
  - On accept of J/JAL, the next cycle drives jump_branch_valid = 1 for exactly one cycle with target {fetch_pc[31:26], instr[25:0]}, and state goes RUN→REDIRECT.
  - The jump itself is still passed downstream.
  - REDIRECT lasts one cycle with fetch_read_enable = 0, then returns to RUN.
- Execute redirect:
  - When ex_redirect_valid = 1: fetch_read_enable = 0 that cycle.
  - At the edge: dec_valid ← 0 (held instruction squashed, even if dec_ready = 1, and not counted), jump_branch_valid ← 1, jump_branch_address ← ex_redirect_address, state ← REDIRECT.
- Priority: reset > ex_redirect > local jump. An ex_redirect arriving during REDIRECT overrides the pending target and restarts the REDIRECT cycle.
- Branches (0x04–0x07) and JR are not resolved here.
- Counters:
  - instr_count += 1 on each dec_valid && dec_ready that is not squashed.
  - redirect_count += 1 per cycle with jump_branch_valid = 1.
  - Both wrap modulo 2^CNT_WIDTH.
- fetch_empty = 1: no accept; the stage drains normally.

Test Plan:
- Reset, then fetch_empty=0 with ADDI 0x2008FFFF at pc=5, dec_ready=1 → next cycle dec_valid=1, dec_pc=5, dec_is_alu_i=1, dec_rt=8, dec_imm=0xFFFFFFFF; instr_count=1 one cycle after handshake.
- ORI 0x3508FFFF, then LUI 0x3C081234 → dec_imm=0x0000FFFF, then 0x12340000.
- JAL 0x0C000040 at pc=0x10 → next cycle jump_branch_valid=1 for one cycle with address 0x00000040; fetch_read_enable=0 that cycle; dec_is_jump=dec_is_link=1; redirect_count=1.
- dec_ready=0 for 3 cycles with dec_valid=1 and fetch non-empty → fetch_read_enable=0 and dec_* unchanged; first cycle dec_ready=1 → new instruction accepted on the same edge.
- ex_redirect_valid=1, address 0x200, while holding an instruction with dec_ready=1 → dec_valid=0 next cycle, jump_branch_valid=1 with 0x200, instr_count unchanged. The same test with a simultaneous J accept-candidate → only 0x200 is issued.
- Opcode 0x3F → dec_illegal=1 with all other flags 0; reset asserted while in REDIRECT → all outputs 0 next cycle.

Source files
------------

// File: rtl/i_decode.sv
// rtl/i_decode.sv - decode stage: field split, immediate/class generation, J/JAL and execute redirect
module i_decode #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_empty,
  input  logic [DATA_WIDTH-1:0]    fetch_instruction,
  input  logic [ADDRESS_WIDTH-1:0] fetch_pc,
  output logic                     fetch_read_enable,
  output logic                     jump_branch_valid,
  output logic [ADDRESS_WIDTH-1:0] jump_branch_address,
  input  logic                     ex_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] ex_redirect_address,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [ADDRESS_WIDTH-1:0] dec_pc,
  output logic [DATA_WIDTH-1:0]    dec_instruction,
  output logic [5:0]               dec_opcode,
  output logic [4:0]               dec_rs,
  output logic [4:0]               dec_rt,
  output logic [4:0]               dec_rd,
  output logic [4:0]               dec_shamt,
  output logic [5:0]               dec_funct,
  output logic [DATA_WIDTH-1:0]    dec_imm,
  output logic                     dec_is_alu_r,
  output logic                     dec_is_alu_i,
  output logic                     dec_is_load,
  output logic                     dec_is_store,
  output logic                     dec_is_branch,
  output logic                     dec_is_jump,
  output logic                     dec_is_link,
  output logic                     dec_illegal,
  output logic [CNT_WIDTH-1:0]     instr_count,
  output logic [CNT_WIDTH-1:0]     redirect_count
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     dec_valid_q, dec_valid_d;
  logic [ADDRESS_WIDTH-1:0] dec_pc_q, dec_pc_d;
  logic [DATA_WIDTH-1:0]    dec_instruction_q, dec_instruction_d;
  logic [DATA_WIDTH-1:0]    dec_imm_q, dec_imm_d;
  logic [7:0]               flags_q, flags_d;
  logic                     jbv_q, jbv_d;
  logic [ADDRESS_WIDTH-1:0] jba_q, jba_d;
  logic [CNT_WIDTH-1:0]     instr_count_q, instr_count_d;
  logic [CNT_WIDTH-1:0]     redirect_count_q, redirect_count_d;

  logic [5:0]               opcode;
  logic [7:0]               class_flags;
  logic [DATA_WIDTH-1:0]    imm_ext;
  logic [ADDRESS_WIDTH-1:0] jump_target;
  logic                     accept;
  logic                     handshake;

  assign accept = (state_q == RUN) && !ex_redirect_valid && !fetch_empty && (!dec_valid_q || dec_ready);
  assign handshake = dec_valid_q && dec_ready && !ex_redirect_valid;
  assign opcode = fetch_instruction[31:26];
  assign jump_target = {fetch_pc[ADDRESS_WIDTH-1:26], fetch_instruction[25:0]};

  // flag order: {alu_r, alu_i, load, store, branch, jump, link, illegal}
  always_comb begin
    class_flags = 8'b0000_0001;
    case (opcode)
      6'h00:                             class_flags = 8'b1000_0000;
      6'h02:                             class_flags = 8'b0000_0100;
      6'h03:                             class_flags = 8'b0000_0110;
      6'h04, 6'h05, 6'h06, 6'h07:        class_flags = 8'b0000_1000;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        class_flags = 8'b0100_0000;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: class_flags = 8'b0010_0000;
      6'h28, 6'h29, 6'h2B:               class_flags = 8'b0001_0000;
      default:                           class_flags = 8'b0000_0001;
    endcase
  end

  always_comb begin
    imm_ext = {{(DATA_WIDTH-16){fetch_instruction[15]}}, fetch_instruction[15:0]};
    if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
      imm_ext = {{(DATA_WIDTH-16){1'b0}}, fetch_instruction[15:0]};
    else if (opcode == 6'h0F)
      imm_ext = {fetch_instruction[15:0], {(DATA_WIDTH-16){1'b0}}};
  end

  always_comb begin
    state_d           = RUN;
    dec_valid_d       = dec_valid_q;
    dec_pc_d          = dec_pc_q;
    dec_instruction_d = dec_instruction_q;
    dec_imm_d         = dec_imm_q;
    flags_d           = flags_q;
    jbv_d             = 1'b0;
    jba_d             = jba_q;
    // an execute redirect squashes whatever is held and wins over a local jump
    if (ex_redirect_valid) begin
      dec_valid_d = 1'b0;
      jbv_d       = 1'b1;
      jba_d       = ex_redirect_address;
      state_d     = REDIRECT;
    end else if (accept) begin
      dec_valid_d       = 1'b1;
      dec_pc_d          = fetch_pc;
      dec_instruction_d = fetch_instruction;
      dec_imm_d         = imm_ext;
      flags_d           = class_flags;
      if (class_flags[2]) begin
        jbv_d   = 1'b1;
        jba_d   = jump_target;
        state_d = REDIRECT;
      end
    end else if (handshake) begin
      dec_valid_d = 1'b0;
    end
    instr_count_d    = handshake ? instr_count_q + CNT_WIDTH'(1) : instr_count_q;
    redirect_count_d = jbv_q ? redirect_count_q + CNT_WIDTH'(1) : redirect_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= RUN;
      dec_valid_q       <= 1'b0;
      dec_pc_q          <= '0;
      dec_instruction_q <= '0;
      dec_imm_q         <= '0;
      flags_q           <= '0;
      jbv_q             <= 1'b0;
      jba_q             <= '0;
      instr_count_q     <= '0;
      redirect_count_q  <= '0;
    end else begin
      state_q           <= state_d;
      dec_valid_q       <= dec_valid_d;
      dec_pc_q          <= dec_pc_d;
      dec_instruction_q <= dec_instruction_d;
      dec_imm_q         <= dec_imm_d;
      flags_q           <= flags_d;
      jbv_q             <= jbv_d;
      jba_q             <= jba_d;
      instr_count_q     <= instr_count_d;
      redirect_count_q  <= redirect_count_d;
    end
  end

  assign fetch_read_enable   = accept;
  assign jump_branch_valid   = jbv_q;
  assign jump_branch_address = jba_q;
  assign dec_valid           = dec_valid_q;
  assign dec_pc              = dec_pc_q;
  assign dec_instruction     = dec_instruction_q;
  assign dec_opcode          = dec_instruction_q[31:26];
  assign dec_rs              = dec_instruction_q[25:21];
  assign dec_rt              = dec_instruction_q[20:16];
  assign dec_rd              = dec_instruction_q[15:11];
  assign dec_shamt           = dec_instruction_q[10:6];
  assign dec_funct           = dec_instruction_q[5:0];
  assign dec_imm             = dec_imm_q;
  assign dec_is_alu_r        = flags_q[7];
  assign dec_is_alu_i        = flags_q[6];
  assign dec_is_load         = flags_q[5];
  assign dec_is_store        = flags_q[4];
  assign dec_is_branch       = flags_q[3];
  assign dec_is_jump         = flags_q[2];
  assign dec_is_link         = flags_q[1];
  assign dec_illegal         = flags_q[0];
  assign instr_count         = instr_count_q;
  assign redirect_count      = redirect_count_q;

endmodule

// File: tb/tb_i_decode.sv
// tb/tb_i_decode.sv - randomized and directed bench for i_decode against a transaction-level model
module tb_i_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_empty = 1'b1;
  logic [31:0] fetch_instruction = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_read_enable;
  logic        jump_branch_valid;
  logic [31:0] jump_branch_address;
  logic        ex_redirect_valid = 1'b0;
  logic [31:0] ex_redirect_address = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_pc, dec_instruction, dec_imm;
  logic [5:0]  dec_opcode, dec_funct;
  logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
  logic        dec_is_alu_r, dec_is_alu_i, dec_is_load, dec_is_store;
  logic        dec_is_branch, dec_is_jump, dec_is_link, dec_illegal;
  logic [31:0] instr_count, redirect_count;
  logic [7:0]  dut_flags;

  int checks = 0;
  int errors = 0;

  i_decode dut (
    .clk(clk), .reset(reset), .fetch_empty(fetch_empty),
    .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
    .fetch_read_enable(fetch_read_enable), .jump_branch_valid(jump_branch_valid),
    .jump_branch_address(jump_branch_address), .ex_redirect_valid(ex_redirect_valid),
    .ex_redirect_address(ex_redirect_address), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instruction(dec_instruction), .dec_opcode(dec_opcode),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_shamt(dec_shamt),
    .dec_funct(dec_funct), .dec_imm(dec_imm), .dec_is_alu_r(dec_is_alu_r),
    .dec_is_alu_i(dec_is_alu_i), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_branch(dec_is_branch), .dec_is_jump(dec_is_jump), .dec_is_link(dec_is_link),
    .dec_illegal(dec_illegal), .instr_count(instr_count), .redirect_count(redirect_count)
  );

  assign dut_flags = {dec_is_alu_r, dec_is_alu_i, dec_is_load, dec_is_store,
                      dec_is_branch, dec_is_jump, dec_is_link, dec_illegal};

  always #5 clk = ~clk;

  // model of the stage as seen from its ports
  logic        m_valid = 0, m_has = 0, m_busy = 0, m_jbv = 0;
  logic [31:0] m_pc = 0, m_instr = 0, m_jba = 0;
  int unsigned m_icount = 0, m_rcount = 0;

  function automatic logic [7:0] ref_flags(input logic [31:0] ins);
    int o = int'(ins[31:26]);
    logic alu_r = (o == 0);
    logic jmp   = (o == 2) || (o == 3);
    logic link  = (o == 3);
    logic br    = (o >= 4) && (o <= 7);
    logic alu_i = (o >= 8) && (o <= 15);
    logic ld    = (o == 32) || (o == 33) || (o == 35) || (o == 36) || (o == 37);
    logic st    = (o == 40) || (o == 41) || (o == 43);
    logic ill   = !(alu_r || jmp || br || alu_i || ld || st);
    return {alu_r, alu_i, ld, st, br, jmp, link, ill};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int o = int'(ins[31:26]);
    logic [31:0] low = ins & 32'h0000FFFF;
    if (o >= 12 && o <= 14) return low;
    if (o == 15) return low * 32'h10000;
    return ins[15] ? (low | 32'hFFFF0000) : low;
  endfunction

  function automatic logic exp_fre();
    return !m_busy && !ex_redirect_valid && !fetch_empty && (!m_valid || dec_ready);
  endfunction

  function automatic void model_edge();
    logic take = exp_fre();
    logic hs = m_valid && dec_ready && !ex_redirect_valid;
    if (reset) begin
      m_valid = 0; m_has = 0; m_busy = 0; m_jbv = 0;
      m_pc = 0; m_instr = 0; m_jba = 0; m_icount = 0; m_rcount = 0;
      return;
    end
    if (hs) m_icount++;
    if (m_jbv) m_rcount++;
    m_jbv = 0; m_busy = 0;
    if (ex_redirect_valid) begin
      m_valid = 0; m_jbv = 1; m_busy = 1; m_jba = ex_redirect_address;
    end else if (take) begin
      m_valid = 1; m_has = 1; m_pc = fetch_pc; m_instr = fetch_instruction;
      if (ref_flags(fetch_instruction)[2]) begin
        m_jbv = 1; m_busy = 1;
        m_jba = (fetch_pc & 32'hFC000000) | (fetch_instruction & 32'h03FFFFFF);
      end
    end else if (hs) begin
      m_valid = 0;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; fetch_empty = 1; ex_redirect_valid = 0; dec_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    idle_inputs();
    checks++; if ({dec_valid, jump_branch_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", {dec_valid, jump_branch_valid}); end
    checks++; if ({dut_flags, dec_instruction, dec_pc, dec_imm} !== '0) begin errors++; $display("FAIL reset_fields got %h/%h/%h/%h exp 0", dut_flags, dec_instruction, dec_pc, dec_imm); end
    checks++; if ({jump_branch_address, instr_count, redirect_count} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", jump_branch_address, instr_count, redirect_count); end
  endtask

  task automatic test_addi();
    fetch_empty = 0; fetch_instruction = 32'h2008FFFF; fetch_pc = 5; dec_ready = 1;
    #1;
    checks++; if (fetch_read_enable !== 1'b1) begin errors++; $display("FAIL addi_fre got %b exp 1", fetch_read_enable); end
    tick();
    fetch_empty = 1;
    checks++; if ({dec_valid, dec_pc} !== {1'b1, 32'd5}) begin errors++; $display("FAIL addi_valid_pc got %b/%h exp 1/5", dec_valid, dec_pc); end
    checks++; if ({dec_is_alu_i, dut_flags, dec_rt} !== {1'b1, 8'h40, 5'd8}) begin errors++; $display("FAIL addi_class got %h rt %0d exp 40 rt 8", dut_flags, dec_rt); end
    checks++; if (dec_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", dec_imm); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL addi_cnt_before got %0d exp 0", instr_count); end
    tick();
    checks++; if ({dec_valid, instr_count} !== {1'b0, 32'd1}) begin errors++; $display("FAIL addi_cnt got %b/%0d exp 0/1", dec_valid, instr_count); end
  endtask

  task automatic test_imm();
    fetch_empty = 0; fetch_instruction = 32'h3508FFFF; fetch_pc = 6;
    tick();
    fetch_instruction = 32'h3C081234; fetch_pc = 7;
    checks++; if (dec_imm !== 32'h0000FFFF) begin errors++; $display("FAIL ori_imm got %h exp 0000ffff", dec_imm); end
    tick();
    fetch_empty = 1;
    checks++; if (dec_imm !== 32'h12340000) begin errors++; $display("FAIL lui_imm got %h exp 12340000", dec_imm); end
    tick();
  endtask

  task automatic test_jal();
    fetch_empty = 0; fetch_instruction = 32'h0C000040; fetch_pc = 32'h10;
    tick();
    fetch_instruction = 32'h2008FFFF; fetch_pc = 32'h11;
    #1;
    checks++; if ({jump_branch_valid, jump_branch_address} !== {1'b1, 32'h40}) begin errors++; $display("FAIL jal_pulse got %b/%h exp 1/00000040", jump_branch_valid, jump_branch_address); end
    checks++; if (fetch_read_enable !== 1'b0) begin errors++; $display("FAIL jal_fre got %b exp 0", fetch_read_enable); end
    checks++; if ({dec_is_jump, dec_is_link, dut_flags} !== {2'b11, 8'h06}) begin errors++; $display("FAIL jal_flags got %h exp 06", dut_flags); end
    tick();
    checks++; if ({jump_branch_valid, redirect_count} !== {1'b0, 32'd1}) begin errors++; $display("FAIL jal_once got %b/%0d exp 0/1", jump_branch_valid, redirect_count); end
    checks++; if (fetch_read_enable !== 1'b1) begin errors++; $display("FAIL jal_resume got %b exp 1", fetch_read_enable); end
    tick();
    fetch_empty = 1;
    checks++; if ({dec_instruction, dec_pc} !== {32'h2008FFFF, 32'h11}) begin errors++; $display("FAIL jal_next got %h@%h exp 2008ffff@11", dec_instruction, dec_pc); end
    tick();
  endtask

  task automatic test_stall();
    fetch_empty = 0; fetch_instruction = 32'h8C220004; fetch_pc = 32'h20; dec_ready = 1;
    tick();
    dec_ready = 0; fetch_instruction = 32'hAC230008; fetch_pc = 32'h24;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fetch_read_enable !== 1'b0) begin errors++; $display("FAIL stall_fre[%0d] got %b exp 0", i, fetch_read_enable); end
      tick();
      checks++; if ({dec_valid, dec_instruction, dec_pc, dut_flags} !== {1'b1, 32'h8C220004, 32'h20, 8'h20}) begin errors++; $display("FAIL stall_hold[%0d] got %b %h@%h %h", i, dec_valid, dec_instruction, dec_pc, dut_flags); end
    end
    dec_ready = 1;
    #1;
    checks++; if (fetch_read_enable !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", fetch_read_enable); end
    tick();
    fetch_empty = 1;
    checks++; if ({dec_valid, dec_instruction, dut_flags} !== {1'b1, 32'hAC230008, 8'h10}) begin errors++; $display("FAIL stall_next got %b %h %h exp 1 ac230008 10", dec_valid, dec_instruction, dut_flags); end
    tick();
  endtask

  task automatic test_ex_redirect();
    int unsigned ic;
    fetch_empty = 0; fetch_instruction = 32'h2008FFFF; fetch_pc = 32'h30;
    tick();
    ic = m_icount;
    fetch_empty = 1; ex_redirect_valid = 1; ex_redirect_address = 32'h200; dec_ready = 1;
    #1;
    checks++; if (fetch_read_enable !== 1'b0) begin errors++; $display("FAIL exr_fre got %b exp 0", fetch_read_enable); end
    tick();
    ex_redirect_valid = 0;
    checks++; if ({dec_valid, jump_branch_valid, jump_branch_address} !== {2'b01, 32'h200}) begin errors++; $display("FAIL exr_squash got %b%b %h exp 01 200", dec_valid, jump_branch_valid, jump_branch_address); end
    checks++; if (instr_count !== ic) begin errors++; $display("FAIL exr_count got %0d exp %0d", instr_count, ic); end
    tick();
    fetch_empty = 0; fetch_instruction = 32'h2008FFFF; fetch_pc = 32'h40;
    tick();
    fetch_instruction = 32'h08000123; fetch_pc = 32'h44;
    ex_redirect_valid = 1; ex_redirect_address = 32'h200;
    tick();
    ex_redirect_valid = 0; fetch_empty = 1;
    checks++; if ({dec_valid, jump_branch_valid, jump_branch_address} !== {2'b01, 32'h200}) begin errors++; $display("FAIL exr_j_pulse got %b%b %h exp 01 200", dec_valid, jump_branch_valid, jump_branch_address); end
    tick();
    checks++; if ({dec_valid, jump_branch_valid, jump_branch_address} !== {2'b00, 32'h200}) begin errors++; $display("FAIL exr_j_none got %b%b %h exp 00 200", dec_valid, jump_branch_valid, jump_branch_address); end
  endtask

  task automatic test_illegal_reset();
    fetch_empty = 0; fetch_instruction = 32'hFC000000; fetch_pc = 32'h50;
    tick();
    checks++; if ({dut_flags, dec_opcode} !== {8'h01, 6'h3F}) begin errors++; $display("FAIL illegal got %h op %h exp 01 op 3f", dut_flags, dec_opcode); end
    fetch_instruction = 32'h08000010; fetch_pc = 32'h54;
    tick();
    checks++; if (jump_branch_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", jump_branch_valid); end
    reset = 1; fetch_empty = 1;
    tick();
    checks++; if ({dec_valid, jump_branch_valid, fetch_read_enable, dut_flags, jump_branch_address} !== '0) begin errors++; $display("FAIL rst_mid_ctl got %b%b%b %h %h exp 0", dec_valid, jump_branch_valid, fetch_read_enable, dut_flags, jump_branch_address); end
    checks++; if ({dec_instruction, dec_pc, dec_imm, instr_count, redirect_count} !== '0) begin errors++; $display("FAIL rst_mid_data got %h %h %h %0d %0d exp 0", dec_instruction, dec_pc, dec_imm, instr_count, redirect_count); end
    reset = 0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ef;
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      fetch_empty = ($urandom_range(0, 9) < 3);
      fetch_instruction = $urandom;
      fetch_pc = $urandom;
      dec_ready = ($urandom_range(0, 9) < 7);
      ex_redirect_valid = ($urandom_range(0, 19) == 0);
      ex_redirect_address = $urandom;
      #1;
      checks++; if (fetch_read_enable !== exp_fre()) begin errors++; $display("FAIL rnd_fre[%0d] got %b exp %b", i, fetch_read_enable, exp_fre()); end
      tick();
      ef = m_has ? ref_flags(m_instr) : 8'h00;
      checks++; if ({dec_valid, jump_branch_valid, jump_branch_address} !== {m_valid, m_jbv, m_jba}) begin errors++; $display("FAIL rnd_ctl[%0d] got %b%b %h exp %b%b %h", i, dec_valid, jump_branch_valid, jump_branch_address, m_valid, m_jbv, m_jba); end
      checks++; if ({dec_instruction, dec_pc} !== {m_instr, m_pc}) begin errors++; $display("FAIL rnd_word[%0d] got %h@%h exp %h@%h", i, dec_instruction, dec_pc, m_instr, m_pc); end
      checks++; if (dut_flags !== ef) begin errors++; $display("FAIL rnd_flags[%0d] got %h exp %h", i, dut_flags, ef); end
      checks++; if (dec_imm !== (m_has ? ref_imm(m_instr) : 32'h0)) begin errors++; $display("FAIL rnd_imm[%0d] got %h exp %h", i, dec_imm, ref_imm(m_instr)); end
      checks++; if ({dec_opcode, dec_rs, dec_rt, dec_rd, dec_shamt, dec_funct} !== m_instr) begin errors++; $display("FAIL rnd_fields[%0d] got %h exp %h", i, {dec_opcode, dec_rs, dec_rt, dec_rd, dec_shamt, dec_funct}, m_instr); end
      checks++; if ({instr_count, redirect_count} !== {m_icount, m_rcount}) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", i, instr_count, redirect_count, m_icount, m_rcount); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm();
    test_jal();
    test_stall();
    test_ex_redirect();
    test_illegal_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
